// File: rtl/route_lookup_arb.sv
// route_lookup_arb: two-requester round-robin front end for a route TCAM.
// Serialises lookups and route-table writes so that only one is ever outstanding.
// Ports: clk/rst; req_* lookup requests (2 requesters); rsp_* lookup results;
//        cfg_* table-write requests with cfg_err on a bad index; tcam_* table side.
// Optional: define ROUTE_ARB_STATS_EN to add stats_clr, lookup_cnt, miss_cnt, wr_cnt.
module route_lookup_arb #(
    parameter int WIDTH = 32,
    parameter int SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req_addr0,
    input  logic [WIDTH-1:0]     req_addr1,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic                 rsp_hit,
    output logic [3:0]           rsp_if_idx,
    output logic [WIDTH-1:0]     rsp_net,
    output logic [7:0]           rsp_prefix_size,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [7:0]           cfg_index,
    input  logic [2*WIDTH+3:0]   cfg_entry,
    output logic                 cfg_err,
    output logic [2*WIDTH+3:0]   tcam_addr_in,
    output logic                 tcam_wr_en,
    output logic [7:0]           tcam_wr_index,
    input  logic [WIDTH-1:0]     tcam_addr_out,
    input  logic [3:0]           tcam_if_idx,
    input  logic [7:0]           tcam_prefix_size,
    input  logic                 tcam_valid
`ifdef ROUTE_ARB_STATS_EN
    ,
    input  logic                 stats_clr,
    output logic [31:0]          lookup_cnt,
    output logic [31:0]          miss_cnt,
    output logic [15:0]          wr_cnt
`endif
);

    localparam int EW = 2 * WIDTH + 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOOKUP = 3'd1;
    localparam logic [2:0] WAIT   = 3'd2;
    localparam logic [2:0] RESP   = 3'd3;
    localparam logic [2:0] WRITE  = 3'd4;

    localparam logic [8:0] SIZE_L = 9'(SIZE);

    logic [2:0]       state_q, state_d;
    logic             last_q, last_d;
    logic [EW-1:0]    addr_q, addr_d;
    logic [7:0]       wr_idx_q, wr_idx_d;
    logic             id_q, id_d;
    logic             hit_q, hit_d;
    logic [3:0]       ifx_q, ifx_d;
    logic [WIDTH-1:0] net_q, net_d;
    logic [7:0]       pfx_q, pfx_d;
    logic             err_q, err_d;

    logic any_req;
    logic win;
    logic idx_ok;
    logic idle;

    assign idle    = (state_q == IDLE);
    assign any_req = |req_valid;
    // With both requesting, the one not granted last time wins.
    assign win     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    assign idx_ok  = ({1'b0, cfg_index} < SIZE_L);

    // Handshake readies are combinational, so they are masked during reset.
    assign cfg_ready = !rst && idle;
    assign req_ready = (!rst && idle && !cfg_valid && any_req)
                       ? (win ? 2'b10 : 2'b01) : 2'b00;

    assign rsp_valid       = (state_q == RESP);
    assign rsp_id          = id_q;
    assign rsp_hit         = hit_q;
    assign rsp_if_idx      = ifx_q;
    assign rsp_net         = net_q;
    assign rsp_prefix_size = pfx_q;
    assign cfg_err         = err_q;
    assign tcam_addr_in    = addr_q;
    assign tcam_wr_en      = (state_q == WRITE);
    assign tcam_wr_index   = wr_idx_q;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        addr_d   = addr_q;
        wr_idx_d = wr_idx_q;
        id_d     = id_q;
        hit_d    = hit_q;
        ifx_d    = ifx_q;
        net_d    = net_q;
        pfx_d    = pfx_q;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    if (idx_ok) begin
                        addr_d   = cfg_entry;
                        wr_idx_d = cfg_index;
                        state_d  = WRITE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (any_req) begin
                    addr_d  = {{(WIDTH + 4){1'b0}},
                               (win ? req_addr1 : req_addr0)};
                    id_d    = win;
                    last_d  = win;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = WAIT;
            WAIT: begin
                // Table output is valid one cycle after it sampled the address.
                hit_d   = tcam_valid;
                ifx_d   = tcam_valid ? tcam_if_idx : 4'd0;
                net_d   = tcam_valid ? tcam_addr_out : '0;
                pfx_d   = tcam_valid ? tcam_prefix_size : 8'd0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            WRITE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            addr_q   <= '0;
            wr_idx_q <= '0;
            id_q     <= 1'b0;
            hit_q    <= 1'b0;
            ifx_q    <= '0;
            net_q    <= '0;
            pfx_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            wr_idx_q <= wr_idx_d;
            id_q     <= id_d;
            hit_q    <= hit_d;
            ifx_q    <= ifx_d;
            net_q    <= net_d;
            pfx_q    <= pfx_d;
            err_q    <= err_d;
        end
    end

`ifdef ROUTE_ARB_STATS_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic        rsp_hs;
    logic        wr_start;

    assign rsp_hs   = rsp_valid && rsp_ready;
    assign wr_start = idle && cfg_valid && idx_ok;

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        wr_cnt_d     = wr_cnt_q;
        if (stats_clr) begin
            lookup_cnt_d = '0;
            miss_cnt_d   = '0;
            wr_cnt_d     = '0;
        end else begin
            if (rsp_hs && lookup_cnt_q != '1)
                lookup_cnt_d = lookup_cnt_q + 32'd1;
            if (rsp_hs && !hit_q && miss_cnt_q != '1)
                miss_cnt_d = miss_cnt_q + 32'd1;
            if (wr_start && wr_cnt_q != '1)
                wr_cnt_d = wr_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lookup_cnt_q <= '0;
            miss_cnt_q   <= '0;
            wr_cnt_q     <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            wr_cnt_q     <= wr_cnt_d;
        end
    end

    assign lookup_cnt = lookup_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign wr_cnt     = wr_cnt_q;
`endif

endmodule

// File: tb/tb_route_lookup_arb.sv
// tb_route_lookup_arb: scoreboard bench for route_lookup_arb with a
// behavioural longest-prefix route table attached to the tcam_* side.
module tb_route_lookup_arb;

    localparam int W  = 32;
    localparam int EW = 2 * W + 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [1:0]    req_ready;
    logic [W-1:0]  req_addr0;
    logic [W-1:0]  req_addr1;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_id;
    logic          rsp_hit;
    logic [3:0]    rsp_if_idx;
    logic [W-1:0]  rsp_net;
    logic [7:0]    rsp_prefix_size;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [7:0]    cfg_index;
    logic [EW-1:0] cfg_entry;
    logic          cfg_err;
    logic [EW-1:0] tcam_addr_in;
    logic          tcam_wr_en;
    logic [7:0]    tcam_wr_index;
    logic [W-1:0]  tcam_addr_out = '0;
    logic [3:0]    tcam_if_idx = '0;
    logic [7:0]    tcam_prefix_size = '0;
    logic          tcam_valid = 1'b0;

    route_lookup_arb #(.WIDTH(W), .SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_hit(rsp_hit),
        .rsp_if_idx(rsp_if_idx), .rsp_net(rsp_net),
        .rsp_prefix_size(rsp_prefix_size),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_index(cfg_index), .cfg_entry(cfg_entry), .cfg_err(cfg_err),
        .tcam_addr_in(tcam_addr_in), .tcam_wr_en(tcam_wr_en),
        .tcam_wr_index(tcam_wr_index), .tcam_addr_out(tcam_addr_out),
        .tcam_if_idx(tcam_if_idx), .tcam_prefix_size(tcam_prefix_size),
        .tcam_valid(tcam_valid)
    );

    always #5 clk = ~clk;

    // Route table: registered longest-prefix match, one-cycle latency.
    logic [EW-1:0] tbl [8];
    logic [7:0]    tbl_v = '0;
    logic          m_hit;
    logic [W-1:0]  m_net;
    logic [3:0]    m_if;
    logic [7:0]    m_pfx;
    int            m_len;

    always_comb begin
        m_hit = 1'b0;
        m_net = '0;
        m_if  = '0;
        m_pfx = '0;
        m_len = -1;
        for (int i = 0; i < 8; i++) begin
            if (tbl_v[i] &&
                ((tcam_addr_in[W-1:0] & tbl[i][2*W-1:W]) == tbl[i][W-1:0]) &&
                int'($countones(tbl[i][2*W-1:W])) > m_len) begin
                m_len = int'($countones(tbl[i][2*W-1:W]));
                m_hit = 1'b1;
                m_net = tbl[i][W-1:0];
                m_if  = tbl[i][EW-1:2*W];
                m_pfx = 8'(m_len);
            end
        end
    end

    always @(posedge clk) begin
        if (tcam_wr_en) begin
            tbl[tcam_wr_index[2:0]]   <= tcam_addr_in;
            tbl_v[tcam_wr_index[2:0]] <= 1'b1;
        end
        tcam_valid       <= m_hit;
        tcam_addr_out    <= m_net;
        tcam_if_idx      <= m_if;
        tcam_prefix_size <= m_pfx;
    end

    typedef struct packed {
        logic       id;
        logic       hit;
        logic [3:0] ifx;
        logic [W-1:0] net;
        logic [7:0] pfx;
    } rsp_t;

    rsp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;

    function automatic rsp_t mk(input logic id, input logic hit,
                                input logic [3:0] ifx, input logic [W-1:0] net,
                                input logic [7:0] pfx);
        rsp_t r;
        r.id = id; r.hit = hit; r.ifx = ifx; r.net = net; r.pfx = pfx;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [71:0] got,
                       input logic [71:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor: every response handshake is checked against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rsp_unexpected: got id=%0d hit=%0d expected none",
                         rsp_id, rsp_hit);
            end else begin
                chk("rsp_fields",
                    72'({rsp_id, rsp_hit, rsp_if_idx, rsp_net, rsp_prefix_size}),
                    72'(sb.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_outs"},
            72'({req_ready, cfg_ready, rsp_valid, rsp_id, rsp_hit, rsp_if_idx,
                 rsp_net, rsp_prefix_size, cfg_err, tcam_wr_en, tcam_wr_index}),
            72'(0));
        chk({tag, "_tcam_addr"}, 72'(tcam_addr_in), 72'(0));
    endtask

    task automatic do_cfg(input logic [7:0] idx, input logic [EW-1:0] ent,
                          input bit ok);
        int c;
        cfg_valid = 1'b1;
        cfg_index = idx;
        cfg_entry = ent;
        c = 0;
        #1;
        while (!cfg_ready && c < 20) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("cfg_ready", 72'(cfg_ready), 72'(1));
        tick;
        cfg_valid = 1'b0;
        if (ok) begin
            chk("wr_en_on", 72'(tcam_wr_en), 72'(1));
            chk("wr_index", 72'(tcam_wr_index), 72'(idx));
            chk("wr_entry", 72'(tcam_addr_in), 72'(ent));
            chk("cfg_err_quiet", 72'(cfg_err), 72'(0));
        end else begin
            chk("cfg_err_pulse", 72'(cfg_err), 72'(1));
            chk("wr_en_blocked", 72'(tcam_wr_en), 72'(0));
        end
        tick;
        chk("wr_en_1cyc", 72'(tcam_wr_en), 72'(0));
        chk("cfg_err_1cyc", 72'(cfg_err), 72'(0));
    endtask

    task automatic issue(input logic id, input logic [W-1:0] addr,
                         input rsp_t exp);
        int c;
        sb.push_back(exp);
        if (id) begin
            req_addr1 = addr;
            req_valid = 2'b10;
        end else begin
            req_addr0 = addr;
            req_valid = 2'b01;
        end
        c = 0;
        #1;
        while (!req_ready[id] && c < 20) begin
            @(posedge clk);
            #2;
            c++;
        end
        chk("req_grant", 72'(req_ready), 72'(id ? 2'b10 : 2'b01));
        tick;
        req_valid = 2'b00;
    endtask

    task automatic wait_done;
        for (int c = 0; c < 60 && sb.size() != 0; c++) tick;
        chk("rsp_drain", 72'(sb.size()), 72'(0));
        tick;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        req_valid = 2'b00;
        req_addr0 = '0;
        req_addr1 = '0;
        rsp_ready = 1'b1;
        cfg_valid = 1'b0;
        cfg_index = '0;
        cfg_entry = '0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        tick;

        // Write a /24 route and hit it from requester 0.
        do_cfg(8'd0, {4'd2, 32'hffffff00, 32'hc0a80000}, 1'b1);
        sb.push_back(mk(1'b0, 1'b1, 4'd2, 32'hc0a80000, 8'd24));
        req_addr0 = 32'hc0a8000a;
        req_valid = 2'b01;
        #1;
        chk("t1_ready", 72'(req_ready), 72'(2'b01));
        tick;
        req_valid = 2'b00;
        chk("t1_lat_n0", 72'(rsp_valid), 72'(0));
        tick;
        chk("t1_lat_n1", 72'(rsp_valid), 72'(0));
        tick;
        chk("t1_lat_n2", 72'(rsp_valid), 72'(1));
        wait_done;

        // Miss: all result fields zero.
        issue(1'b0, 32'h0a00000a, mk(1'b0, 1'b0, 4'd0, 32'h0, 8'd0));
        wait_done;
        issue(1'b1, 32'h0a000001, mk(1'b1, 1'b0, 4'd0, 32'h0, 8'd0));
        wait_done;

        // Both requesters held: grants alternate 0,1,0,1.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                sb.push_back(mk(1'b0, 1'b1, 4'd2, 32'hc0a80000, 8'd24));
            else
                sb.push_back(mk(1'b1, 1'b0, 4'd0, 32'h0, 8'd0));
        end
        req_addr0 = 32'hc0a80001;
        req_addr1 = 32'h0b000001;
        req_valid = 2'b11;
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            #1;
            if (req_ready != 2'b00) begin
                chk("rr_grant", 72'(req_ready), 72'((n % 2) ? 2'b10 : 2'b01));
                n++;
            end
            tick;
        end
        req_valid = 2'b00;
        chk("rr_count", 72'(n), 72'(4));
        wait_done;

        // Write and lookup together: write wins, lookup sees the new route.
        sb.push_back(mk(1'b0, 1'b1, 4'd5, 32'h0a000000, 8'd8));
        req_addr0 = 32'h0a000005;
        cfg_index = 8'd1;
        cfg_entry = {4'd5, 32'hff000000, 32'h0a000000};
        cfg_valid = 1'b1;
        req_valid = 2'b01;
        #1;
        chk("prio_cfg_ready", 72'(cfg_ready), 72'(1));
        chk("prio_req_held", 72'(req_ready), 72'(0));
        tick;
        cfg_valid = 1'b0;
        chk("prio_wr_en", 72'(tcam_wr_en), 72'(1));
        chk("prio_req_wr", 72'(req_ready), 72'(0));
        tick;
        chk("prio_wr_done", 72'(tcam_wr_en), 72'(0));
        chk("prio_req_after", 72'(req_ready), 72'(2'b01));
        tick;
        req_valid = 2'b00;
        wait_done;

        // Out-of-range write index.
        do_cfg(8'd8, {4'd7, 32'hffffffff, 32'h01020304}, 1'b0);

        // Back-pressure: response held stable, no new grant.
        rsp_ready = 1'b0;
        issue(1'b0, 32'hc0a80077, mk(1'b0, 1'b1, 4'd2, 32'hc0a80000, 8'd24));
        req_addr1 = 32'h0b000002;
        req_valid = 2'b10;
        tick;
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid", 72'(rsp_valid), 72'(1));
            chk("stall_fields",
                72'({rsp_id, rsp_hit, rsp_if_idx, rsp_net, rsp_prefix_size}),
                72'(mk(1'b0, 1'b1, 4'd2, 32'hc0a80000, 8'd24)));
            chk("stall_no_grant", 72'(req_ready), 72'(0));
            tick;
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        wait_done;

        // Reset while a lookup sits in WAIT.
        req_addr0 = 32'hc0a80001;
        req_valid = 2'b01;
        tick;
        req_valid = 2'b00;
        tick;
        req_valid = 2'b11;
        cfg_valid = 1'b1;
        cfg_index = 8'd2;
        rst = 1'b1;
        #1;
        check_zero("rst_wait");
        tick;
        check_zero("rst_hold");
        cfg_valid = 1'b0;
        req_valid = 2'b00;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("rst_no_stale", 72'(rsp_valid), 72'(0));
        end
        sb.push_back(mk(1'b0, 1'b1, 4'd2, 32'hc0a80000, 8'd24));
        req_valid = 2'b11;
        #1;
        chk("rst_ptr", 72'(req_ready), 72'(2'b01));
        tick;
        req_valid = 2'b00;
        wait_done;

        chk("sb_empty", 72'(sb.size()), 72'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/route_lookup_arb.md
ROUTE_LOOKUP_ARB -- requirements
Module: route_lookup_arb

Interface
REQ-001 Parameters SHALL be, one per line:
  WIDTH  32  address width, equal to the route table address width
  SIZE   8   number of table entries; legal write indexes are 0..SIZE-1
REQ-002 Ports SHALL be, one per line:
  clk              in   1           single clock; all state changes on its rising edge
  rst              in   1           asynchronous reset, active-high
  req_valid        in   2           lookup request from requester 0 (bit 0) and requester 1 (bit 1)
  req_ready        out  2           lookup request accepted on valid&ready
  req_addr0        in   WIDTH       destination address from requester 0
  req_addr1        in   WIDTH       destination address from requester 1
  rsp_valid        out  1           lookup result available
  rsp_ready        in   1           result consumed on valid&ready
  rsp_id           out  1           requester that issued the lookup
  rsp_hit          out  1           a matching route exists
  rsp_if_idx       out  4           egress interface index
  rsp_net          out  WIDTH       matched network prefix
  rsp_prefix_size  out  8           matched prefix length
  cfg_valid        in   1           route-table write request
  cfg_ready        out  1           write accepted on valid&ready
  cfg_index        in   8           entry to write
  cfg_entry        in   2*WIDTH+4   {if_idx[3:0], netmask, prefix}
  cfg_err          out  1           one-cycle pulse: write rejected because cfg_index >= SIZE
  tcam_addr_in     out  2*WIDTH+4   to table: lookup address in [WIDTH-1:0], or a write entry
  tcam_wr_en       out  1           to table: write strobe
  tcam_wr_index    out  8           to table: write index
  tcam_addr_out    in   WIDTH       from table: matched net
  tcam_if_idx      in   4           from table: matched interface
  tcam_prefix_size in   8           from table: matched prefix length
  tcam_valid       in   1           from table: hit

Function
REQ-003 The FSM SHALL have states IDLE, LOOKUP, WAIT, RESP, WRITE, and SHALL accept requests only in IDLE.
REQ-004 In IDLE, a pending cfg_valid SHALL take priority over lookups: cfg_ready=1 and req_ready=0.
REQ-005 In IDLE with cfg_valid=0, exactly one req_ready bit SHALL be high: the round-robin winner among the requesters asserting req_valid, with the non-last-granted requester winning when both request; all req_ready bits are 0 when no requester is valid.
REQ-006 On lookup acceptance at edge N, the block SHALL register the winner's address into tcam_addr_in[WIDTH-1:0], zero the upper bits, record rsp_id and the last-grant pointer, and go to LOOKUP.
REQ-007 The FSM SHALL step LOOKUP->WAIT at N+1 (table samples the address) and WAIT->RESP at N+2, capturing the table outputs so that rsp_valid=1 from N+2.
REQ-008 On a miss (tcam_valid=0), the block SHALL drive rsp_hit=0 and SHALL zero rsp_if_idx, rsp_net and rsp_prefix_size.
REQ-009 In RESP, all rsp_* outputs SHALL be held stable until rsp_valid&rsp_ready, and the FSM SHALL then return to IDLE.
REQ-010 On cfg acceptance with cfg_index<SIZE, the FSM SHALL enter WRITE for exactly one cycle, driving tcam_wr_en=1, tcam_addr_in=cfg_entry and tcam_wr_index=cfg_index, then return to IDLE.
REQ-011 On cfg acceptance with cfg_index>=SIZE, the block SHALL pulse cfg_err for one cycle, keep tcam_wr_en low, and stay in IDLE.
REQ-012 tcam_wr_en SHALL never be high outside WRITE, and the block SHALL never have more than one lookup or write outstanding.

Reset
REQ-013 While rst=1, the block SHALL force state IDLE, the last-grant pointer to requester 1 (so requester 0 wins first), and all outputs to 0, and SHALL discard any in-flight lookup or response.

Configuration
REQ-014 With ROUTE_ARB_STATS_EN defined, the block SHALL add input stats_clr and outputs lookup_cnt[31:0], miss_cnt[31:0] and wr_cnt[15:0]:
  - counters increment on response handshake, on miss response handshake, and on WRITE entry respectively;
  - counters saturate at all-ones;
  - stats_clr clears them synchronously, and rst clears them.
  Without the macro, these ports and their logic SHALL be absent.

Verification
REQ-015 Bench scenarios SHALL be:
  - cfg write idx 0 = {if 2, mask ffffff00, c0a80000}, then lookup c0a8000a from req 0 -> tcam_wr_en high for 1 cycle; rsp_valid 2 cycles after acceptance, rsp_hit=1, if_idx=2, net c0a80000, prefix 24, id 0.
  - lookup 0a00000a with no matching route -> rsp_hit=0, all result fields 0.
  - both req_valid held continuously for 4 lookups -> grants alternate 0,1,0,1.
  - cfg_valid and req_valid asserted together in IDLE -> write first, lookup after.
  - cfg_index=8 -> cfg_err pulse, no tcam_wr_en; rsp_ready low for 5 cycles -> rsp fields stable, no new req_ready; rst asserted in WAIT -> all outputs 0 asynchronously, IDLE after release.
